instr_exec_sequencer: RTL and testbench

- Sequences execution of a block of instructions already loaded into the instruction register.
- On start, it walks read addresses from a base for a given count and captures each instruction word after the register's read latency.
- For each instruction it computes the 65-bit result in an ALU sub-module and presents it on a valid/ready result stream tagged with its address.
- Sits between the test/controller side and the instruction register's read port.

---
 rtl/instr_exec_sequencer_pkg.sv | 24 ++
 rtl/instr_alu.sv | 39 +++
 rtl/instr_exec_sequencer.sv | 138 +++++++++++++
 tb/tb_instr_exec_sequencer.sv | 410 ++++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/instr_exec_sequencer_pkg.sv
// Shared types for the instruction execution sequencer: operand/result widths,
// opcode set, result flags and sequencer FSM states.
package instr_exec_sequencer_pkg;
  typedef logic [4:0]  address_t;
  typedef logic [31:0] operand_t;
  typedef logic [64:0] result_t;

  typedef enum logic [3:0] {
    ZERO = 4'd0, PASSA = 4'd1, PASSB = 4'd2, ADD = 4'd3,
    SUB  = 4'd4, MULT  = 4'd5, DIV   = 4'd6, MOD = 4'd7
  } opcode_t;

  typedef struct packed {
    logic illegal_op;
    logic div_zero;
  } res_flags_t;

  typedef enum logic [2:0] {IDLE, FETCH, WAIT, EXEC, OUT, DONE} seq_state_t;

  // Encodings 8..15 are reserved.
  function automatic logic is_legal(opcode_t opc);
    return ~opc[3];
  endfunction
endpackage

// File: rtl/instr_alu.sv
// Combinational signed ALU: 32-bit operands widened to 65 bits so every
// opcode, including -2^31 / -1, is exact.
module instr_alu import instr_exec_sequencer_pkg::*; (
  input  opcode_t    i_opc,
  input  operand_t   i_op_a,
  input  operand_t   i_op_b,
  output result_t    o_result,
  output res_flags_t o_flags
);
  logic signed [64:0] w_a, w_b;

  assign w_a = {{33{i_op_a[31]}}, i_op_a};
  assign w_b = {{33{i_op_b[31]}}, i_op_b};

  always_comb begin
    o_result = '0;
    o_flags  = '0;
    if (!is_legal(i_opc)) begin
      o_flags.illegal_op = 1'b1;
    end else begin
      case (i_opc)
        PASSA: o_result = w_a;
        PASSB: o_result = w_b;
        ADD:   o_result = w_a + w_b;
        SUB:   o_result = w_a - w_b;
        MULT:  o_result = w_a * w_b;
        DIV: begin
          if (w_b == '0) o_flags.div_zero = 1'b1;
          else           o_result = w_a / w_b;
        end
        MOD: begin
          if (w_b == '0) o_flags.div_zero = 1'b1;
          else           o_result = w_a % w_b;
        end
        default: o_result = '0;
      endcase
    end
  end
endmodule

// File: rtl/instr_exec_sequencer.sv
// Walks a block of instruction-register addresses, executes each word through
// instr_alu and streams the results out on a valid/ready port.
module instr_exec_sequencer import instr_exec_sequencer_pkg::*; #(
  parameter int RD_LATENCY = 1,
  parameter int MAX_COUNT  = 32
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       start,
  input  address_t   base_addr,
  input  logic [5:0] count,
  input  logic       abort,
  output address_t   read_pointer,
  input  opcode_t    rd_opc,
  input  operand_t   rd_op_a,
  input  operand_t   rd_op_b,
  output logic       res_valid,
  input  logic       res_ready,
  output result_t    res_data,
  output address_t   res_addr,
  output res_flags_t res_flags,
  output logic       busy,
  output logic       done
);
  localparam logic [1:0] LAT_LAST = 2'(RD_LATENCY - 1);

  seq_state_t r_state;
  address_t   r_addr;
  logic [5:0] r_remain;
  logic [1:0] r_lat;
  opcode_t    r_opc;
  operand_t   r_a, r_b;
  logic       r_res_valid, r_busy, r_done;
  result_t    r_res_data;
  address_t   r_res_addr;
  res_flags_t r_res_flags;

  logic [5:0] w_count;
  result_t    w_result;
  res_flags_t w_flags;

  assign w_count = (count > 6'(MAX_COUNT)) ? 6'(MAX_COUNT) : count;

  instr_alu u_alu (
    .i_opc    (r_opc),
    .i_op_a   (r_a),
    .i_op_b   (r_b),
    .o_result (w_result),
    .o_flags  (w_flags)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state     <= IDLE;
      r_addr      <= '0;
      r_remain    <= '0;
      r_lat       <= '0;
      r_opc       <= ZERO;
      r_a         <= '0;
      r_b         <= '0;
      r_res_valid <= 1'b0;
      r_res_data  <= '0;
      r_res_addr  <= '0;
      r_res_flags <= '0;
      r_busy      <= 1'b0;
      r_done      <= 1'b0;
    end else begin
      r_done <= 1'b0;
      if (abort && r_state != IDLE) begin
        r_state     <= IDLE;
        r_res_valid <= 1'b0;
        r_busy      <= 1'b0;
      end else begin
        case (r_state)
          IDLE: begin
            if (start) begin
              if (w_count == '0) begin
                r_done <= 1'b1;
              end else begin
                r_addr   <= base_addr;
                r_remain <= w_count;
                r_busy   <= 1'b1;
                r_state  <= FETCH;
              end
            end
          end
          FETCH: begin
            r_lat   <= '0;
            r_state <= WAIT;
          end
          WAIT: begin
            if (r_lat == LAT_LAST) begin
              r_opc   <= rd_opc;
              r_a     <= rd_op_a;
              r_b     <= rd_op_b;
              r_state <= EXEC;
            end else begin
              r_lat <= r_lat + 2'd1;
            end
          end
          EXEC: begin
            r_res_data  <= w_result;
            r_res_flags <= w_flags;
            r_res_addr  <= r_addr;
            r_res_valid <= 1'b1;
            r_state     <= OUT;
          end
          OUT: begin
            if (r_res_valid && res_ready) begin
              r_res_valid <= 1'b0;
              r_remain    <= r_remain - 6'd1;
              if (r_remain == 6'd1) begin
                r_done  <= 1'b1;
                r_state <= DONE;
              end else begin
                r_addr  <= r_addr + 5'd1;
                r_state <= FETCH;
              end
            end
          end
          DONE: begin
            r_busy  <= 1'b0;
            r_state <= IDLE;
          end
          default: r_state <= IDLE;
        endcase
      end
    end
  end

  assign read_pointer = r_addr;
  assign res_valid    = r_res_valid;
  assign res_data     = r_res_data;
  assign res_addr     = r_res_addr;
  assign res_flags    = r_res_flags;
  assign busy         = r_busy;
  assign done         = r_done;
endmodule

// File: tb/tb_instr_exec_sequencer.sv
// Bench for instr_exec_sequencer: a latency-1 and a latency-2 instance share
// stimulus; results are checked against a longint reference of the opcode rules.
module tb_instr_exec_sequencer;
  import instr_exec_sequencer_pkg::*;

  logic clk = 1'b0;
  logic reset = 1'b1;
  logic start = 1'b0, abort = 1'b0, res_ready = 1'b1;
  address_t base_addr = '0;
  logic [5:0] count = '0;

  address_t read_pointer, res_addr, read_pointer2, res_addr2;
  opcode_t rd_opc, rd2_opc, p_opc;
  operand_t rd_op_a, rd_op_b, rd2_op_a, rd2_op_b, p_a, p_b;
  logic res_valid, busy, done, res_valid2, busy2, done2;
  result_t res_data, res_data2;
  res_flags_t res_flags, res_flags2;

  opcode_t  mem_opc[32];
  operand_t mem_a[32], mem_b[32];

  int n_checks = 0, n_errors = 0;
  logic [64:0] q_data[$];
  logic [4:0]  q_addr[$];
  logic [1:0]  q_flags[$];
  int q_t[$];
  int n_done, first_v, first_v2, first_done;
  bit timed_out;

  always #5 clk = ~clk;

  instr_exec_sequencer #(.RD_LATENCY(1), .MAX_COUNT(32)) dut (
    .clk(clk), .reset(reset), .start(start), .base_addr(base_addr), .count(count),
    .abort(abort), .read_pointer(read_pointer), .rd_opc(rd_opc), .rd_op_a(rd_op_a),
    .rd_op_b(rd_op_b), .res_valid(res_valid), .res_ready(res_ready), .res_data(res_data),
    .res_addr(res_addr), .res_flags(res_flags), .busy(busy), .done(done));

  instr_exec_sequencer #(.RD_LATENCY(2), .MAX_COUNT(32)) dut2 (
    .clk(clk), .reset(reset), .start(start), .base_addr(base_addr), .count(count),
    .abort(abort), .read_pointer(read_pointer2), .rd_opc(rd2_opc), .rd_op_a(rd2_op_a),
    .rd_op_b(rd2_op_b), .res_valid(res_valid2), .res_ready(res_ready), .res_data(res_data2),
    .res_addr(res_addr2), .res_flags(res_flags2), .busy(busy2), .done(done2));

  // Instruction register read ports: one and two cycles of read latency.
  always @(posedge clk) begin
    rd_opc  <= mem_opc[read_pointer];
    rd_op_a <= mem_a[read_pointer];
    rd_op_b <= mem_b[read_pointer];
    p_opc   <= mem_opc[read_pointer2];
    p_a     <= mem_a[read_pointer2];
    p_b     <= mem_b[read_pointer2];
    rd2_opc  <= p_opc;
    rd2_op_a <= p_a;
    rd2_op_b <= p_b;
  end

  function automatic void ref_alu(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b,
                                  output logic [64:0] r, output logic [1:0] f);
    longint sa, sb, v;
    sa = longint'(signed'(a));
    sb = longint'(signed'(b));
    v = 0;
    f = 2'b00;
    case (op)
      4'd0: v = 0;
      4'd1: v = sa;
      4'd2: v = sb;
      4'd3: v = sa + sb;
      4'd4: v = sa - sb;
      4'd5: v = sa * sb;
      4'd6: if (sb == 0) f = 2'b01; else v = sa / sb;
      4'd7: if (sb == 0) f = 2'b01; else v = sa % sb;
      default: f = 2'b10;
    endcase
    r = {v[63], v};
  endfunction

  task automatic load(input int addr, input opcode_t o, input int a, input int b);
    mem_opc[addr] = o;
    mem_a[addr] = a;
    mem_b[addr] = b;
  endtask

  task automatic randomize_mem();
    for (int i = 0; i < 32; i++) begin
      mem_opc[i] = opcode_t'(4'($urandom_range(15)));
      mem_a[i] = $urandom;
      mem_b[i] = ($urandom_range(7) == 0) ? 32'd0 : $urandom;
    end
  endtask

  // Return both instances to IDLE between scenarios.
  task automatic settle();
    @(negedge clk);
    abort = 1'b1;
    res_ready = 1'b1;
    @(negedge clk);
    abort = 1'b0;
    @(negedge clk);
  endtask

  // Starts a run and records every handshake; inj>0 issues a second start at that cycle.
  task automatic run(input logic [4:0] b, input logic [5:0] c, input int pct, input int inj);
    q_data.delete(); q_addr.delete(); q_flags.delete(); q_t.delete();
    n_done = 0; first_v = -1; first_v2 = -1; first_done = -1; timed_out = 1'b0;
    @(negedge clk);
    start = 1'b1; base_addr = b; count = c;
    @(negedge clk);
    start = 1'b0;
    for (int t = 1; ; t++) begin
      if (res_valid && first_v < 0) first_v = t;
      if (res_valid2 && first_v2 < 0) first_v2 = t;
      if (done) begin
        n_done++;
        if (first_done < 0) first_done = t;
      end
      if (n_done > 0 && !busy) break;
      if (t > 1500) begin
        timed_out = 1'b1;
        break;
      end
      start = (t == inj);
      if (t == inj) begin
        base_addr = 5'd20;
        count = 6'd5;
      end
      res_ready = ($urandom_range(99) < pct);
      if (res_valid && res_ready) begin
        q_data.push_back(res_data);
        q_addr.push_back(res_addr);
        q_flags.push_back(res_flags);
        q_t.push_back(t);
      end
      @(negedge clk);
    end
    start = 1'b0;
    settle();
  endtask

  task automatic test_reset();
    repeat (2) @(negedge clk);
    n_checks++;
    if ({res_valid, busy, done} !== 3'b000) begin
      n_errors++; $display("FAIL reset_ctrl got %b want 000", {res_valid, busy, done});
    end
    n_checks++;
    if (read_pointer !== 5'd0 || res_addr !== 5'd0) begin
      n_errors++; $display("FAIL reset_addr got rp=%0d ra=%0d want 0", read_pointer, res_addr);
    end
    n_checks++;
    if (res_data !== 65'd0 || res_flags !== 2'b00) begin
      n_errors++; $display("FAIL reset_data got %h/%b want 0", res_data, res_flags);
    end
    reset = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_basic();
    longint lit[4] = '{12, -7, -24, 99};
    logic [63:0] v;
    load(0, ADD, 5, 7); load(1, SUB, 3, 10); load(2, MULT, -4, 6); load(3, PASSB, 0, 99);
    run(5'd0, 6'd4, 100, -1);
    n_checks++;
    if (timed_out || q_data.size() != 4) begin
      n_errors++; $display("FAIL basic_count got %0d results (timeout=%0d) want 4", q_data.size(), timed_out);
    end else begin
      for (int i = 0; i < 4; i++) begin
        v = lit[i];
        n_checks++;
        if (q_data[i] !== {v[63], v} || q_addr[i] !== 5'(i) || q_flags[i] !== 2'b00) begin
          n_errors++;
          $display("FAIL basic_result[%0d] got %h@%0d f%b want %h@%0d f00", i, q_data[i], q_addr[i], q_flags[i], {v[63], v}, i);
        end
        n_checks++;
        if (q_t[i] !== 4 + 4 * i) begin
          n_errors++; $display("FAIL basic_timing[%0d] got cycle %0d want %0d", i, q_t[i], 4 + 4 * i);
        end
      end
    end
    n_checks++;
    if (n_done !== 1) begin
      n_errors++; $display("FAIL basic_done got %0d pulses want 1", n_done);
    end
    n_checks++;
    if (first_v2 !== 5) begin
      n_errors++; $display("FAIL lat2_first_valid got %0d want 5", first_v2);
    end
    n_checks++;
    if (read_pointer !== 5'd3) begin
      n_errors++; $display("FAIL idle_pointer_hold got %0d want 3", read_pointer);
    end
  endtask

  task automatic test_wrap();
    logic [64:0] er; logic [1:0] ef; int a;
    randomize_mem();
    run(5'd30, 6'd4, 100, -1);
    n_checks++;
    if (timed_out || q_data.size() != 4) begin
      n_errors++; $display("FAIL wrap_count got %0d want 4", q_data.size());
    end else begin
      for (int i = 0; i < 4; i++) begin
        a = (30 + i) % 32;
        ref_alu(mem_opc[a], mem_a[a], mem_b[a], er, ef);
        n_checks++;
        if (q_addr[i] !== 5'(a) || q_data[i] !== er || q_flags[i] !== ef) begin
          n_errors++;
          $display("FAIL wrap[%0d] got %h@%0d f%b want %h@%0d f%b", i, q_data[i], q_addr[i], q_flags[i], er, a, ef);
        end
      end
    end
  endtask

  task automatic test_boundary();
    logic [64:0] want_d[4];
    logic [1:0] want_f[4];
    load(10, DIV, 7, 0); load(11, MOD, -7, 2);
    load(12, opcode_t'(4'hF), 5, 6); load(13, DIV, 32'h8000_0000, -1);
    want_d = '{65'd0, {65{1'b1}}, 65'd0, 65'h0_8000_0000};
    want_f = '{2'b01, 2'b00, 2'b10, 2'b00};
    run(5'd10, 6'd4, 100, -1);
    n_checks++;
    if (timed_out || q_data.size() != 4) begin
      n_errors++; $display("FAIL boundary_count got %0d want 4", q_data.size());
    end else begin
      for (int i = 0; i < 4; i++) begin
        n_checks++;
        if (q_data[i] !== want_d[i] || q_flags[i] !== want_f[i]) begin
          n_errors++;
          $display("FAIL boundary[%0d] got %h f%b want %h f%b", i, q_data[i], q_flags[i], want_d[i], want_f[i]);
        end
      end
    end
  endtask

  task automatic test_backpressure();
    logic [64:0] d0; logic [4:0] a0; int w;
    load(9, ADD, 100, -1); load(10, SUB, 1, 2);
    res_ready = 1'b0;
    @(negedge clk);
    start = 1'b1; base_addr = 5'd9; count = 6'd2;
    @(negedge clk);
    start = 1'b0;
    w = 0;
    while (!res_valid && w < 20) begin @(negedge clk); w++; end
    n_checks++;
    if (res_valid !== 1'b1 || res_data !== 65'd99) begin
      n_errors++; $display("FAIL bp_first got v=%b d=%h want v=1 d=63", res_valid, res_data);
    end
    d0 = res_data; a0 = res_addr;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      n_checks++;
      if (res_valid !== 1'b1 || res_data !== d0 || res_addr !== a0 || read_pointer !== 5'd9) begin
        n_errors++;
        $display("FAIL bp_hold[%0d] got v=%b d=%h a=%0d rp=%0d want v=1 d=%h a=%0d rp=9", i, res_valid, res_data, res_addr, read_pointer, d0, a0);
      end
    end
    res_ready = 1'b1;
    @(negedge clk);
    n_checks++;
    if (res_valid !== 1'b0 || read_pointer !== 5'd10) begin
      n_errors++; $display("FAIL bp_accept got v=%b rp=%0d want v=0 rp=10", res_valid, read_pointer);
    end
    w = 0;
    while (!res_valid && w < 20) begin @(negedge clk); w++; end
    n_checks++;
    if (res_valid !== 1'b1 || res_data !== {65{1'b1}} || res_addr !== 5'd10) begin
      n_errors++; $display("FAIL bp_second got v=%b d=%h a=%0d want v=1 d=-1 a=10", res_valid, res_data, res_addr);
    end
    settle();
  endtask

  task automatic test_abort();
    int nd;
    res_ready = 1'b1;
    @(negedge clk);
    start = 1'b1; base_addr = 5'd0; count = 6'd4;
    @(negedge clk);
    start = 1'b0;
    repeat (5) @(negedge clk);
    n_checks++;
    if (read_pointer !== 5'd1 || busy !== 1'b1) begin
      n_errors++; $display("FAIL abort_pre got rp=%0d busy=%b want rp=1 busy=1", read_pointer, busy);
    end
    abort = 1'b1;
    @(negedge clk);
    abort = 1'b0;
    n_checks++;
    if (busy !== 1'b0 || res_valid !== 1'b0) begin
      n_errors++; $display("FAIL abort_idle got busy=%b v=%b want 0 0", busy, res_valid);
    end
    nd = 0;
    repeat (8) begin
      @(negedge clk);
      if (done || busy || res_valid) nd++;
    end
    n_checks++;
    if (nd !== 0) begin
      n_errors++; $display("FAIL abort_quiet got %0d active cycles want 0", nd);
    end
  endtask

  task automatic test_start_ignored();
    randomize_mem();
    run(5'd5, 6'd2, 100, 2);
    n_checks++;
    if (q_addr.size() != 2 || q_addr[0] !== 5'd5 || q_addr[1] !== 5'd6 || n_done !== 1) begin
      n_errors++; $display("FAIL start_ignored got %0d results done=%0d want 2 results (5,6) done=1", q_addr.size(), n_done);
    end
  endtask

  task automatic test_count_zero();
    run(5'd7, 6'd0, 100, -1);
    n_checks++;
    if (first_done !== 1 || n_done !== 1 || first_v !== -1 || q_data.size() != 0) begin
      n_errors++;
      $display("FAIL count_zero got done@%0d x%0d valid@%0d want done@1 x1 no valid", first_done, n_done, first_v);
    end
  endtask

  task automatic test_clamp();
    run(5'd0, 6'd40, 100, -1);
    n_checks++;
    if (q_addr.size() != 32 || n_done !== 1) begin
      n_errors++; $display("FAIL clamp got %0d results done=%0d want 32 done=1", q_addr.size(), n_done);
    end else begin
      for (int i = 0; i < 32; i++) begin
        n_checks++;
        if (q_addr[i] !== 5'(i)) begin
          n_errors++; $display("FAIL clamp_addr[%0d] got %0d want %0d", i, q_addr[i], i);
        end
      end
    end
  endtask

  task automatic test_random();
    logic [64:0] er; logic [1:0] ef; int a, b, c, bad;
    for (int it = 0; it < 8; it++) begin
      randomize_mem();
      b = $urandom_range(31);
      c = $urandom_range(12, 1);
      run(5'(b), 6'(c), 55, -1);
      bad = 0;
      for (int i = 0; i < q_data.size(); i++) begin
        a = (b + i) % 32;
        ref_alu(mem_opc[a], mem_a[a], mem_b[a], er, ef);
        if (q_data[i] !== er || q_flags[i] !== ef || q_addr[i] !== 5'(a)) bad++;
      end
      n_checks++;
      if (timed_out || q_data.size() != c || bad != 0 || n_done !== 1) begin
        n_errors++;
        $display("FAIL random[%0d] got %0d results %0d wrong done=%0d want %0d results 0 wrong done=1", it, q_data.size(), bad, n_done, c);
      end
    end
  endtask

  task automatic test_reset_mid();
    int w, nd;
    res_ready = 1'b0;
    @(negedge clk);
    start = 1'b1; base_addr = 5'd5; count = 6'd3;
    @(negedge clk);
    start = 1'b0;
    w = 0;
    while (!res_valid && w < 20) begin @(negedge clk); w++; end
    #2 reset = 1'b1;
    #1;
    n_checks++;
    if (res_valid !== 1'b0 || busy !== 1'b0 || read_pointer !== 5'd0 || res_data !== 65'd0) begin
      n_errors++;
      $display("FAIL reset_mid got v=%b busy=%b rp=%0d d=%h want 0", res_valid, busy, read_pointer, res_data);
    end
    @(negedge clk);
    reset = 1'b0;
    res_ready = 1'b1;
    nd = 0;
    repeat (6) begin
      @(negedge clk);
      if (done || busy) nd++;
    end
    n_checks++;
    if (nd !== 0) begin
      n_errors++; $display("FAIL reset_mid_quiet got %0d active cycles want 0", nd);
    end
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  initial begin
    for (int i = 0; i < 32; i++) load(i, ZERO, 0, 0);
    test_reset();
    test_basic();
    test_wrap();
    test_boundary();
    test_backpressure();
    test_abort();
    test_start_ignored();
    test_count_zero();
    test_clamp();
    test_random();
    test_reset_mid();
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end
endmodule
